present_key_sched_ctrl: RTL and testbench

Sequential PRESENT key-schedule controller. On a start request it loads the cipher key and steps the key register once per accepted round key. It streams round keys 1..NUM_ROUNDS+1 to the round datapath over a valid/ready handshake. It replaces the per-round combinational key update with a single iterated register, shared across all rounds.

---
 rtl/present_key_sched_ctrl.sv | 148 ++++++++++++++
 tb/tb_present_key_sched_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_key_sched_ctrl.sv
// PRESENT key-schedule controller.
// Loads the cipher key when a start is accepted. It then streams round keys
// 1..NUM_ROUNDS+1 over a valid/ready handshake. One iterated key register
// does the work of every round's key update.
// Optional build macro KEY_128_EN selects the 128-bit key variant.
// Without KEY_128_EN the key is 80 bits wide.
module present_key_sched_ctrl #(
   parameter int NUM_ROUNDS = 31,
   parameter int IDX_W      = 5,
`ifdef KEY_128_EN
   localparam int KW        = 128
`else
   localparam int KW        = 80
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [KW-1:0]    key_in,
   input  logic             abort,
   output logic             busy,
   output logic             rk_valid,
   input  logic             rk_ready,
   output logic [63:0]      rk_data,
   output logic [IDX_W-1:0] rk_idx,
   output logic             rk_last,
   output logic             done
);

   // The counter carries one extra bit. This lets NUM_ROUNDS+1 be reached
   // even when it does not fit in the rk_idx width.
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ROUNDS + 1);

   typedef enum logic [1:0] {
      IDLE,
      EMIT,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [KW-1:0]    key_reg;
   logic [KW-1:0]    key_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         default: y = 4'h2;
      endcase
      return y;
   endfunction

   // One key-schedule step. The argument i is the round counter before
   // it is incremented.
   function automatic logic [KW-1:0] key_update(input logic [KW-1:0] k, input logic [4:0] i);
      logic [KW-1:0] r;
`ifdef KEY_128_EN
      r = {k[66:0], k[127:67]};
      r[127:124] = sbox(r[127:124]);
      r[123:120] = sbox(r[123:120]);
      r[66:62]   = r[66:62] ^ i;
`else
      r = {k[18:0], k[79:19]};
      r[79:76] = sbox(r[79:76]);
      r[19:15] = r[19:15] ^ i;
`endif
      return r;
   endfunction

   // State, key and counter registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         key_reg <= '0;
         cnt     <= '0;
      end else begin
         state   <= state_next;
         key_reg <= key_next;
         cnt     <= cnt_next;
      end
   end

   // Next-state, key stepping and handshake outputs; abort masks rk_valid
   always_comb begin
      state_next = state;
      key_next   = key_reg;
      cnt_next   = cnt;
      busy       = 1'b0;
      rk_valid   = 1'b0;
      rk_data    = '0;
      rk_idx     = '0;
      rk_last    = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               key_next   = key_in;
               cnt_next   = CNT_W'(1);
               state_next = EMIT;
            end
         end
         EMIT: begin
            busy     = 1'b1;
            rk_valid = ~abort;
            rk_data  = key_reg[KW-1 -: 64];
            rk_idx   = cnt[IDX_W-1:0];
            rk_last  = ~abort & (cnt == LAST_IDX);
            if (abort) begin
               state_next = IDLE;
            end else if (rk_ready) begin
               if (cnt == LAST_IDX) begin
                  state_next = DONE;
               end else begin
                  key_next = key_update(key_reg, cnt[4:0]);
                  cnt_next = cnt + CNT_W'(1);
               end
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_present_key_sched_ctrl.sv
// Self-checking bench for present_key_sched_ctrl.
// A schedule-level model precomputes every round key when a start is
// accepted. It then follows the handshake to predict the outputs on each
// cycle. Directed scenarios pin the model and the DUT with hand-computed
// values.
// Optional build macro KEY_128_EN selects the 128-bit key variant.
module tb_present_key_sched_ctrl;

`ifdef KEY_128_EN
   localparam int KW = 128;
   localparam logic [63:0]  RK2_ZERO = 64'hCC00000000000000;
   localparam logic [63:0]  RK2_ONES = 64'h22FFFFFFFFFFFFFF;
   localparam logic [127:0] KEY_A    = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] KEY_B    = 128'hFEDCBA98765432100000000000000000;
`else
   localparam int KW = 80;
   localparam logic [63:0]  RK2_ZERO = 64'hC000000000000000;
   localparam logic [63:0]  RK2_ONES = 64'h2FFFFFFFFFFFFFFF;
   localparam logic [127:0] KEY_A    = 128'h0123456789ABCDEF0123;
   localparam logic [127:0] KEY_B    = 128'hFEDCBA9876543210FFFF;
`endif
   localparam logic [63:0]  KEY_B_RK1 = 64'hFEDCBA9876543210;
   localparam logic [127:0] KEY_ONES  = '1;
   localparam logic [127:0] KEY_ZERO  = '0;
   localparam int NR = 31;
   localparam int IW = 6;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [KW-1:0] key_in;
   logic          abort;
   logic          busy;
   logic          rk_valid;
   logic          rk_ready;
   logic [63:0]   rk_data;
   logic [IW-1:0] rk_idx;
   logic          rk_last;
   logic          done;

   int n_cmp = 0;
   int n_bad = 0;

   // The index port is widened so that round key 32 is representable.
   present_key_sched_ctrl #(.NUM_ROUNDS(NR), .IDX_W(IW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .key_in   (key_in),
      .abort    (abort),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_data  (rk_data),
      .rk_idx   (rk_idx),
      .rk_last  (rk_last),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference S-box lookup table.
   logic [3:0] SB [0:15] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   // Reference key step: rotate left by 61, substitute the top nibble(s),
   // then mix in the round counter.
   function automatic logic [KW-1:0] model_next(input logic [KW-1:0] k, input int i);
      logic [KW-1:0] r;
      logic [KW-1:0] ivec;
      r = (k << 61) | (k >> (KW - 61));
      r[KW-1 -: 4] = SB[r[KW-1 -: 4]];
`ifdef KEY_128_EN
      r[KW-5 -: 4] = SB[r[KW-5 -: 4]];
      ivec = KW'(i % 32) << 62;
`else
      ivec = KW'(i % 32) << 15;
`endif
      return r ^ ivec;
   endfunction

   // Model state: 0 = idle, 1 = emitting, 2 = done pulse.
   int            m_mode = 0;
   int            m_idx  = 0;
   bit            m_live = 1'b0;
   logic [KW-1:0] mk [1:NR+1];

   // Schedule-level model, advanced on each rising edge from the sampled inputs
   always @(posedge clk) begin
      if (!rst_n) begin
         m_mode = 0;
         m_idx  = 0;
         m_live = 1'b1;
      end else begin
         case (m_mode)
            0: if (start) begin
                  mk[1] = key_in;
                  for (int j = 1; j <= NR; j++) mk[j+1] = model_next(mk[j], j);
                  m_idx  = 1;
                  m_mode = 1;
               end
            1: if (abort) m_mode = 0;
               else if (rk_ready) begin
                  if (m_idx == NR + 1) m_mode = 2;
                  else m_idx++;
               end
            default: m_mode = 0;
         endcase
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [127:0] k, input logic a, input logic r);
      start    = s;
      key_in   = k[KW-1:0];
      abort    = a;
      rk_ready = r;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle comparison of every DUT output against the model
   always @(negedge clk) begin
      if (m_live) begin
         logic emit;
         emit = (m_mode == 1);
         checkOutput("busy",     64'(busy),     64'(m_mode != 0));
         checkOutput("done",     64'(done),     64'(m_mode == 2));
         checkOutput("rk_valid", 64'(rk_valid), 64'(emit && !abort));
         checkOutput("rk_last",  64'(rk_last),  64'(emit && !abort && m_idx == NR + 1));
         checkOutput("rk_idx",   64'(rk_idx),   emit ? 64'(m_idx) : 64'd0);
         checkOutput("rk_data",  rk_data,       emit ? mk[m_idx][KW-1 -: 64] : 64'd0);
      end
   end

   int xfer_cnt = 0;
   int last_cnt = 0;
   int last_idx = 0;
   int done_cnt = 0;

   // Event counters: transfers, last-key flags and done pulses
   always @(negedge clk) begin
      if (rk_valid === 1'b1 && rk_ready === 1'b1) xfer_cnt++;
      if (rk_last === 1'b1) begin
         last_cnt++;
         last_idx = int'(rk_idx);
      end
      if (done === 1'b1) done_cnt++;
   end

   task automatic waitDone(input int max_cycles, input string name);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < max_cycles; c++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      checkOutput(name, 64'(seen), 64'd1);
      if (seen) begin
         step();
         checkOutput({name, "_after"}, 64'({busy, done, rk_valid}), 64'd0);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int xb;
      int lb;
      int db;
      bit found;

      // Reset state
      rst_n = 1'b0;
      applyStimulus(1'b0, KEY_ZERO, 1'b0, 1'b0);
      step();
      step();
      checkOutput("reset_flags", 64'({busy, rk_valid, rk_last, done}), 64'd0);
      checkOutput("reset_idx",   64'(rk_idx), 64'd0);
      checkOutput("reset_data",  rk_data, 64'd0);
      rst_n = 1'b1;

      // Zero key, full run with rk_ready held high
      $display("[TB] zero key full schedule");
      xb = xfer_cnt;
      lb = last_cnt;
      applyStimulus(1'b1, KEY_ZERO, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, KEY_ZERO, 1'b0, 1'b1);
      checkOutput("s1_rk1_valid", 64'(rk_valid), 64'd1);
      checkOutput("s1_rk1_idx",   64'(rk_idx), 64'd1);
      checkOutput("s1_rk1_data",  rk_data, 64'h0);
      checkOutput("model_rk2_zero", mk[2][KW-1 -: 64], RK2_ZERO);
      step();
      checkOutput("s1_rk2_idx",  64'(rk_idx), 64'd2);
      checkOutput("s1_rk2_data", rk_data, RK2_ZERO);
      waitDone(40, "s1_done");
      checkOutput("s1_xfers",    64'(xfer_cnt - xb), 64'd32);
      checkOutput("s1_last_cnt", 64'(last_cnt - lb), 64'd1);
      checkOutput("s1_last_idx", 64'(last_idx), 64'd32);

      // All-ones key, then abort
      $display("[TB] all-ones key");
      applyStimulus(1'b1, KEY_ONES, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, KEY_ONES, 1'b0, 1'b1);
      checkOutput("s2_rk1_data", rk_data, 64'hFFFFFFFFFFFFFFFF);
      checkOutput("model_rk2_ones", mk[2][KW-1 -: 64], RK2_ONES);
      step();
      checkOutput("s2_rk2_data", rk_data, RK2_ONES);
      applyStimulus(1'b0, KEY_ONES, 1'b1, 1'b1);
      #1;
      checkOutput("s2_abort_valid", 64'(rk_valid), 64'd0);
      step();
      applyStimulus(1'b0, KEY_ONES, 1'b0, 1'b1);
      checkOutput("s2_abort_idle", 64'({busy, rk_valid, done}), 64'd0);

      // Backpressure at round key 2
      $display("[TB] backpressure");
      applyStimulus(1'b1, KEY_ZERO, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, KEY_ZERO, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, KEY_ZERO, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         checkOutput("s3_hold_idx",  64'(rk_idx), 64'd2);
         checkOutput("s3_hold_data", rk_data, RK2_ZERO);
         step();
      end
      applyStimulus(1'b0, KEY_ZERO, 1'b0, 1'b1);
      checkOutput("s3_release_idx", 64'(rk_idx), 64'd2);
      step();
      checkOutput("s3_next_idx", 64'(rk_idx), 64'd3);
      waitDone(40, "s3_done");

      // Abort at round key 10, then restart with a new key
      $display("[TB] abort and restart");
      applyStimulus(1'b1, KEY_A, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, KEY_A, 1'b0, 1'b1);
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (rk_idx == IW'(10)) begin
            found = 1'b1;
            break;
         end
         step();
      end
      checkOutput("s4_reach_idx10", 64'(found), 64'd1);
      db = done_cnt;
      applyStimulus(1'b0, KEY_A, 1'b1, 1'b1);
      #1;
      checkOutput("s4_abort_valid", 64'({rk_valid, rk_last}), 64'd0);
      step();
      applyStimulus(1'b0, KEY_A, 1'b0, 1'b1);
      checkOutput("s4_abort_idle", 64'({busy, rk_valid, done}), 64'd0);
      step();
      step();
      checkOutput("s4_no_done", 64'(done_cnt - db), 64'd0);
      applyStimulus(1'b1, KEY_B, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, KEY_B, 1'b0, 1'b1);
      checkOutput("s4_restart_idx",  64'(rk_idx), 64'd1);
      checkOutput("s4_restart_data", rk_data, KEY_B_RK1);
      waitDone(40, "s4_done");

      // start ignored during EMIT, then reset mid-schedule
      $display("[TB] start during emit and mid-run reset");
      applyStimulus(1'b1, KEY_A, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, KEY_A, 1'b0, 1'b1);
      for (int c = 0; c < 4; c++) step();
      checkOutput("s5_idx5", 64'(rk_idx), 64'd5);
      applyStimulus(1'b1, KEY_B, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, KEY_B, 1'b0, 1'b1);
      checkOutput("s5_start_ignored_idx", 64'(rk_idx), 64'd6);
      step();
      rst_n = 1'b0;
      step();
      checkOutput("s5_reset_flags", 64'({busy, rk_valid, rk_last, done}), 64'd0);
      checkOutput("s5_reset_idx",   64'(rk_idx), 64'd0);
      checkOutput("s5_reset_data",  rk_data, 64'd0);
      rst_n = 1'b1;
      step();

      // start together with abort in IDLE: start wins
      $display("[TB] start with abort in idle");
      applyStimulus(1'b1, KEY_B, 1'b1, 1'b1);
      step();
      applyStimulus(1'b0, KEY_B, 1'b0, 1'b1);
      checkOutput("s6_busy", 64'(busy), 64'd1);
      checkOutput("s6_idx",  64'(rk_idx), 64'd1);
      checkOutput("s6_data", rk_data, KEY_B_RK1);
      waitDone(40, "s6_done");

      checkOutput("total_done_pulses", 64'(done_cnt), 64'd4);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
